// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch (I), data (D) and memory-side handshakes of mem_port_arbiter.
// The arbiter connects through the slave modport; the core/memory environment uses master.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    logic          busy;
    logic [31:0]   i_wait_cnt;
    logic [31:0]   d_wait_cnt;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata,
               busy, i_wait_cnt, d_wait_cnt
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata,
               busy, i_wait_cnt, d_wait_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch (I) and data (D) ports, D-priority with I anti-starvation.
// Define ARB_PERF_CNT_EN to build the I/D stall-cycle counters; otherwise those outputs read 0.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    localparam int            LW    = $clog2(STARVE_LIMIT + 1) + 1;
    localparam logic [LW-1:0] LIMIT = LW'(STARVE_LIMIT);

    logic [1:0]    state;
    logic [LW-1:0] loseCnt;
    logic          mReq;
    logic          mWe;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWdata;
    logic          iAck;
    logic          dAck;
    logic [DW-1:0] iRdata;
    logic [DW-1:0] dRdata;

    logic ackCycle;
    logic bothReq;
    logic grantI;
    logic grantD;

    // The ack cycle is spent in IDLE but never grants: it is the mandatory bubble.
    always_comb begin
        ackCycle = iAck | dAck;
        bothReq  = bus.i_req & bus.d_req;
        grantI   = 1'b0;
        grantD   = 1'b0;
        if (state == IDLE && !ackCycle) begin
            if (bothReq) begin
                if (STARVE_LIMIT != 0 && loseCnt == LIMIT) grantI = 1'b1;
                else                                       grantD = 1'b1;
            end else begin
                grantI = bus.i_req;
                grantD = bus.d_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            loseCnt <= '0;
            mReq    <= 1'b0;
            mWe     <= 1'b0;
            mAddr   <= '0;
            mWdata  <= '0;
            iAck    <= 1'b0;
            dAck    <= 1'b0;
            iRdata  <= '0;
            dRdata  <= '0;
        end else begin
            iAck <= 1'b0;
            dAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantI) begin
                        state   <= SERVE_I;
                        mReq    <= 1'b1;
                        mWe     <= 1'b0;
                        mAddr   <= bus.i_addr;
                        mWdata  <= '0;
                        loseCnt <= '0;
                    end else if (grantD) begin
                        state  <= SERVE_D;
                        mReq   <= 1'b1;
                        mWe    <= bus.d_we;
                        mAddr  <= bus.d_addr;
                        mWdata <= bus.d_wdata;
                        if (bothReq && loseCnt != LIMIT) loseCnt <= loseCnt + 1'b1;
                    end
                end
                SERVE_I: begin
                    if (bus.m_ready) begin
                        state  <= IDLE;
                        mReq   <= 1'b0;
                        iAck   <= 1'b1;
                        iRdata <= bus.m_rdata;
                    end
                end
                SERVE_D: begin
                    if (bus.m_ready) begin
                        state <= IDLE;
                        mReq  <= 1'b0;
                        dAck  <= 1'b1;
                        if (!mWe) dRdata <= bus.m_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_req   = mReq;
    assign bus.m_we    = mWe;
    assign bus.m_addr  = mAddr;
    assign bus.m_wdata = mWdata;
    assign bus.i_ack   = iAck;
    assign bus.d_ack   = dAck;
    assign bus.i_rdata = iRdata;
    assign bus.d_rdata = dRdata;
    assign bus.busy    = (state != IDLE);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] iWaitCnt;
    logic [31:0] dWaitCnt;

    // Stall cycles as seen by the core: request up, no ack yet; saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            iWaitCnt <= '0;
            dWaitCnt <= '0;
        end else begin
            if (bus.i_req && !iAck && iWaitCnt != 32'hFFFF_FFFF) iWaitCnt <= iWaitCnt + 32'd1;
            if (bus.d_req && !dAck && dWaitCnt != 32'hFFFF_FFFF) dWaitCnt <= dWaitCnt + 32'd1;
        end
    end

    assign bus.i_wait_cnt = iWaitCnt;
    assign bus.d_wait_cnt = dWaitCnt;
`else
    assign bus.i_wait_cnt = 32'd0;
    assign bus.d_wait_cnt = 32'd0;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipelined core's instruction-fetch port (I) and data load/store port (D).
- Grants one requester at a time and registers its address, write-enable and write data.
- Drives the memory handshake and returns read data with a one-cycle ack pulse.
- The core uses the missing ack as its stall condition (I feeds the StallF path, D holds the M stage).

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive tie losses the I port may suffer before it is forced a grant; 0 = strict D priority.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch data; valid when i_ack=1
- i_ack  out  1  fetch complete, one-cycle pulse
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid when d_ack=1
- d_ack  out  1  data access complete, one-cycle pulse
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data; valid with m_ready
- m_ready  in  1  memory completes the current request this cycle
- busy  out  1  a transaction is in flight (state != IDLE)
- i_wait_cnt  out  32  I stall-cycle counter (optional feature)
- d_wait_cnt  out  32  D stall-cycle counter (optional feature)

Behaviour:
- Reset values: all outputs 0, state IDLE, lose_cnt=0. A reset in the middle of a transaction abandons it: m_req drops at that edge and no ack is issued.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Only d_req=1: go to SERVE_D.
  - Only i_req=1: go to SERVE_I.
  - Both requesting: D wins unless STARVE_LIMIT!=0 and lose_cnt==STARVE_LIMIT, in which case I wins.
  - On the grant edge, latch the winner's addr, we and wdata (we=0 for I). m_req=1 from the next cycle.
- lose_cnt:
  - Increments (saturating at STARVE_LIMIT) when both request and D wins.
  - Clears whenever I is granted.
  - Holds otherwise.
- SERVE_x:
  - m_req, m_we, m_addr and m_wdata are held constant from registers until the cycle where m_ready=1.
  - On that edge: register m_rdata into x_rdata, pulse x_ack=1 for exactly one cycle, drop m_req, return to IDLE.
  - x_rdata holds its value until the next completion on that port.
  - For stores, d_rdata is left unchanged.
- Latency:
  - Request first seen in cycle N puts m_req=1 in N+1.
  - m_ready in cycle N+1+k gives ack in cycle N+2+k.
  - Minimum is 2 cycles, then a mandatory 1-cycle IDLE bubble between transactions.
- The requester must not sample a new request in its own ack cycle; the arbiter ignores req during the ack cycle because it is still counted as the completed request.
- m_ready while in IDLE is ignored.
- If a requester drops req before its ack, the transaction still completes and the ack still pulses.
- busy=1 in SERVE_I and SERVE_D.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - i_wait_cnt increments on every cycle with i_req=1 and i_ack=0.
  - d_wait_cnt increments likewise for d_req and d_ack.
  - Both are 32-bit, saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports remain in the interface, tied to 0, and no counter registers are built.

Test Plan:
1. Fetch read: i_req=1, i_addr=0x40; m_ready=1 two cycles after m_req with m_rdata=0x00500113 -> m_addr=0x40, m_we=0; i_ack pulses once; i_rdata=0x00500113; busy drops in the ack cycle.
2. Store: d_req=1, d_we=1, d_addr=0x64, d_wdata=0xABCD1234, memory waits 3 cycles -> m_we=1, m_addr=0x64, m_wdata=0xABCD1234 stable all 3 cycles; d_ack pulses once; d_rdata unchanged.
3. Contention: i_req and d_req held high continuously with 1-cycle memory, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; with STARVE_LIMIT=0, I is never granted while d_req=1.
4. Zero-wait memory: m_ready tied to 1, lone d_req load -> d_ack 2 cycles after d_req rises; next grant 1 cycle later (bubble).
5. Reset mid-operation: assert reset during SERVE_D with m_ready=0 -> next cycle m_req=0, busy=0, no d_ack; after release, a fresh i_req is served normally.
6. With ARB_PERF_CNT_EN: d_req held 5 cycles before d_ack -> d_wait_cnt=5 and i_wait_cnt=0. Without the macro, both read 0 throughout.
